// File: rtl/hart_sched_arbiter.sv
// Hart scheduler arbiter: time-slices a shared memory port between harts,
// preempting on quantum expiry, loss of runnability or a foreign interrupt,
// and hands over only once the owning hart reaches a safe switch point.
module hart_sched_arbiter #(
    parameter int unsigned N_HARTS = 4,
    parameter int unsigned QW      = 16,
    localparam int unsigned SEL_W  = (N_HARTS == 1) ? 1 : $clog2(N_HARTS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_HARTS-1:0] i_runnable,
    input  logic [N_HARTS-1:0] i_irq,
    input  logic [N_HARTS-1:0] i_ready,
    input  logic               i_hold,
    input  logic               i_busy,
    input  logic [QW-1:0]      i_quantum,
    output logic [SEL_W-1:0]   o_sel,
    output logic [N_HARTS-1:0] o_sel_oh,
    output logic [N_HARTS-1:0] o_busy,
    output logic               o_switch,
    output logic               o_idle
);

    // Scan index needs one extra bit so o_sel + k (k <= N_HARTS) never overflows.
    localparam int unsigned IW = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [QW-1:0]      cnt;
    logic               preempt;
    logic               any_run;
    logic               irq_found;
    logic               run_found;
    logic [SEL_W-1:0]   irq_pick;
    logic [SEL_W-1:0]   run_pick;
    logic [SEL_W-1:0]   pick;
    logic [N_HARTS-1:0] pick_oh;
    logic [IW-1:0]      scan;
    logic               own_busy;

    assign any_run = |i_runnable;
    assign preempt = ((i_quantum != '0) && (cnt >= (i_quantum - QW'(1))))
                   || !i_runnable[o_sel]
                   || ((|(i_irq & i_runnable & ~o_sel_oh)) && !i_irq[o_sel]);
    assign pick    = irq_found ? irq_pick : run_pick;
    assign pick_oh = N_HARTS'(1) << pick;

    // Rotating scan from o_sel+1 back round to o_sel: interrupting harts first, then any runnable.
    always_comb begin
        irq_found = 1'b0;
        run_found = 1'b0;
        irq_pick  = '0;
        run_pick  = '0;
        scan      = '0;
        for (int k = 1; k <= int'(N_HARTS); k++) begin
            scan = IW'(o_sel) + IW'(k);
            if (scan >= IW'(N_HARTS)) begin
                scan = scan - IW'(N_HARTS);
            end
            if (!irq_found && i_runnable[scan[SEL_W-1:0]] && i_irq[scan[SEL_W-1:0]]) begin
                irq_found = 1'b1;
                irq_pick  = scan[SEL_W-1:0];
            end
            if (!run_found && i_runnable[scan[SEL_W-1:0]]) begin
                run_found = 1'b1;
                run_pick  = scan[SEL_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_run) state_nxt = SWITCH;
            RUN:     if (preempt) state_nxt = DRAIN;
            DRAIN:   if (i_ready[o_sel] && !i_hold) state_nxt = SWITCH;
            SWITCH:  state_nxt = any_run ? RUN : IDLE;
            default: state_nxt = RUN;
        endcase
    end

    // Slice counter, owner registers and switch pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_sel    <= '0;
            o_sel_oh <= N_HARTS'(1);
            cnt      <= '0;
            o_switch <= 1'b0;
        end else begin
            o_switch <= 1'b0;
            case (state)
                IDLE: cnt <= '0;
                RUN: begin
                    if (!i_hold && (cnt != '1)) begin
                        cnt <= cnt + QW'(1);
                    end
                end
                SWITCH: begin
                    cnt <= '0;
                    if (any_run) begin
                        o_sel    <= pick;
                        o_sel_oh <= pick_oh;
                        o_switch <= (pick != o_sel);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: non-owners always see busy; owner sees the port state only while settled.
    always_comb begin
        own_busy = 1'b1;
        if ((state == RUN) || (state == IDLE)) begin
            own_busy = i_busy;
        end
        o_busy = ~o_sel_oh | (o_sel_oh & {N_HARTS{own_busy}});
        o_idle = (state == IDLE);
        if (RST) begin
            o_busy = '1;
            o_idle = 1'b0;
        end
    end

endmodule

// File: tb/tb_hart_sched_arbiter.sv
// Directed bench for hart_sched_arbiter: round robin, interrupt steering,
// drain/hold stalls, idle, single-runnable wrap, quantum changes, reset abort
// and a single-hart instance.
module tb_hart_sched_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned QW = 16;

    logic          CLK;
    logic          RST;
    logic [N-1:0]  runnable;
    logic [N-1:0]  irq;
    logic [N-1:0]  ready;
    logic          hold;
    logic          mbusy;
    logic [QW-1:0] quantum;
    logic [1:0]    sel;
    logic [N-1:0]  sel_oh;
    logic [N-1:0]  busy_v;
    logic          sw;
    logic          idle;

    logic [0:0]    r1;
    logic [0:0]    irq1;
    logic [0:0]    rdy1;
    logic [QW-1:0] q1;
    logic [0:0]    sel1;
    logic [0:0]    oh1;
    logic [0:0]    busy1;
    logic          sw1;
    logic          idle1;

    int checks = 0;
    int errors = 0;
    int n;

    hart_sched_arbiter #(.N_HARTS(N), .QW(QW)) dut (
        .CLK(CLK), .RST(RST),
        .i_runnable(runnable), .i_irq(irq), .i_ready(ready),
        .i_hold(hold), .i_busy(mbusy), .i_quantum(quantum),
        .o_sel(sel), .o_sel_oh(sel_oh), .o_busy(busy_v),
        .o_switch(sw), .o_idle(idle)
    );

    hart_sched_arbiter #(.N_HARTS(1), .QW(QW)) dut1 (
        .CLK(CLK), .RST(RST),
        .i_runnable(r1), .i_irq(irq1), .i_ready(rdy1),
        .i_hold(1'b0), .i_busy(1'b0), .i_quantum(q1),
        .o_sel(sel1), .o_sel_oh(oh1), .o_busy(busy1),
        .o_switch(sw1), .o_idle(idle1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycles (negedges) until o_switch is seen; -1 if the budget runs out.
    task automatic wait_switch(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (!sw && cycles < limit);
        if (!sw) cycles = -1;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", sel); end
        checks++; if (sel_oh !== 4'b0001) begin errors++; $display("FAIL rst_oh: got %b expected 0001", sel_oh); end
        checks++; if (sw !== 1'b0) begin errors++; $display("FAIL rst_switch: got %b expected 0", sw); end
        checks++; if (busy_v !== 4'hF) begin errors++; $display("FAIL rst_busy: got %b expected 1111", busy_v); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b expected 0", idle); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (busy_v !== 4'b1110) begin errors++; $display("FAIL run_busy0: got %b expected 1110", busy_v); end
        mbusy = 1'b1;
        #1;
        checks++; if (busy_v !== 4'b1111) begin errors++; $display("FAIL run_busy1: got %b expected 1111", busy_v); end
        mbusy = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        int exp_n;
        for (int i = 0; i < 4; i++) begin
            wait_switch(40, n);
            exp_sel = 2'((i + 1) % 4);
            exp_n = (i == 0) ? 9 : 10;
            checks++; if (n != exp_n) begin errors++; $display("FAIL rr_gap%0d: got %0d expected %0d", i, n, exp_n); end
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL rr_sel%0d: got %0d expected %0d", i, sel, exp_sel); end
            checks++; if (sel_oh !== (4'b0001 << exp_sel)) begin errors++; $display("FAIL rr_oh%0d: got %b expected %b", i, sel_oh, 4'b0001 << exp_sel); end
        end
    endtask

    task automatic test_irq();
        irq = 4'b0100;
        wait_switch(20, n);
        checks++; if (n != 3) begin errors++; $display("FAIL irq_gap: got %0d expected 3", n); end
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL irq_sel: got %0d expected 2", sel); end
        irq = 4'b0000;
        wait_switch(20, n);
        checks++; if (n != 10) begin errors++; $display("FAIL irq_keep_gap: got %0d expected 10", n); end
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL irq_next_sel: got %0d expected 3", sel); end
    endtask

    task automatic test_drain_hold();
        int bad;
        ready = 4'b0111;
        repeat (8) @(negedge CLK);
        checks++; if (busy_v !== 4'hF) begin errors++; $display("FAIL drain_busy: got %b expected 1111", busy_v); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 15) begin
                ready = 4'b0111;
                hold  = (i % 4 == 1);
            end else begin
                ready = 4'b1111;
                hold  = 1'b1;
            end
            @(negedge CLK);
            if (sel !== 2'd3 || busy_v[3] !== 1'b1 || sw !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL drain_stall: got %0d bad cycles expected 0", bad); end
        hold = 1'b0;
        wait_switch(20, n);
        checks++; if (n != 2) begin errors++; $display("FAIL drain_release_gap: got %0d expected 2", n); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL drain_release_sel: got %0d expected 0", sel); end
    endtask

    task automatic test_idle();
        int pulses;
        runnable = 4'b0000;
        repeat (3) @(negedge CLK);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_flag: got %b expected 1", idle); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL idle_sel: got %0d expected 0", sel); end
        checks++; if (busy_v !== 4'b1110) begin errors++; $display("FAIL idle_busy: got %b expected 1110", busy_v); end
        repeat (4) @(negedge CLK);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_stay: got %b expected 1", idle); end
        runnable = 4'b1000;
        wait_switch(20, n);
        checks++; if (n != 2) begin errors++; $display("FAIL wake_gap: got %0d expected 2", n); end
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL wake_sel: got %0d expected 3", sel); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL wake_idle: got %b expected 0", idle); end
        pulses = 0;
        repeat (12) begin
            @(negedge CLK);
            if (sw) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL wake_extra_pulse: got %0d expected 0", pulses); end
    endtask

    task automatic test_single();
        int bad;
        logic [3:0] exp_busy;
        quantum  = 16'd4;
        runnable = 4'b0010;
        wait_switch(20, n);
        checks++; if (n != 3) begin errors++; $display("FAIL single_gap: got %0d expected 3", n); end
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL single_sel: got %0d expected 1", sel); end
        bad = 0;
        for (int k = 0; k < 18; k++) begin
            exp_busy = (k % 6 >= 4) ? 4'hF : 4'b1101;
            if (sel !== 2'd1 || busy_v !== exp_busy || (k > 0 && sw !== 1'b0)) bad++;
            @(negedge CLK);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_wrap: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_quantum();
        int bad;
        runnable = 4'b1111;
        quantum  = 16'd16;
        wait_switch(40, n);
        checks++; if (n != 18) begin errors++; $display("FAIL q16_gap: got %0d expected 18", n); end
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL q16_sel: got %0d expected 2", sel); end
        repeat (5) @(negedge CLK);
        quantum = 16'd3;
        wait_switch(20, n);
        checks++; if (n != 3) begin errors++; $display("FAIL qlow_gap: got %0d expected 3", n); end
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL qlow_sel: got %0d expected 3", sel); end
        quantum = 16'd4;
        hold    = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (sel !== 2'd3 || sw !== 1'b0 || busy_v !== 4'b0111) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL run_hold: got %0d bad cycles expected 0", bad); end
        hold = 1'b0;
        wait_switch(20, n);
        checks++; if (n != 6) begin errors++; $display("FAIL unhold_gap: got %0d expected 6", n); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL unhold_sel: got %0d expected 0", sel); end
    endtask

    task automatic test_reset_mid_switch();
        wait_switch(20, n);
        wait_switch(20, n);
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL pre_rst_sel: got %0d expected 2", sel); end
        repeat (5) @(negedge CLK);
        checks++; if (busy_v !== 4'hF) begin errors++; $display("FAIL in_switch_busy: got %b expected 1111", busy_v); end
        RST = 1'b1;
        #1;
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_abort_sel: got %0d expected 0", sel); end
        checks++; if (sel_oh !== 4'b0001) begin errors++; $display("FAIL rst_abort_oh: got %b expected 0001", sel_oh); end
        checks++; if (sw !== 1'b0) begin errors++; $display("FAIL rst_abort_sw: got %b expected 0", sw); end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        wait_switch(20, n);
        checks++; if (n != 6) begin errors++; $display("FAIL post_rst_gap: got %0d expected 6", n); end
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL post_rst_sel: got %0d expected 1", sel); end
    endtask

    task automatic test_one_hart();
        int bad;
        int high;
        bad  = 0;
        high = 0;
        repeat (12) begin
            @(negedge CLK);
            if (sel1 !== 1'b0 || oh1 !== 1'b1 || sw1 !== 1'b0) bad++;
            if (busy1 === 1'b1) high++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL one_hart_sel: got %0d bad cycles expected 0", bad); end
        checks++; if (high != 6) begin errors++; $display("FAIL one_hart_period: got %0d busy cycles expected 6", high); end
    endtask

    initial begin
        RST      = 1'b1;
        runnable = 4'b1111;
        irq      = 4'b0000;
        ready    = 4'b1111;
        hold     = 1'b0;
        mbusy    = 1'b0;
        quantum  = 16'd8;
        r1       = 1'b1;
        irq1     = 1'b0;
        rdy1     = 1'b1;
        q1       = 16'd2;
        test_reset();
        test_round_robin();
        test_irq();
        test_drain_hold();
        test_idle();
        test_single();
        test_quantum();
        test_reset_mid_switch();
        test_one_hart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
